// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared definitions for the ID/EX stage: control word layout and bubble value.
package id_ex_hazard_stage_pkg;

    localparam int CTRL_W     = 13;
    localparam int REG_ADDR_W = 5;

    localparam int CTRL_JAL       = 12;
    localparam int CTRL_JUMP      = 11;
    localparam int CTRL_REGDST    = 10;
    localparam int CTRL_ALUSRC    = 9;
    localparam int CTRL_MEMTOREG  = 8;
    localparam int CTRL_REGWRITE  = 7;
    localparam int CTRL_MEMREAD   = 6;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_BNE       = 4;
    localparam int CTRL_BEQ       = 3;
    localparam int CTRL_ALUOP_MSB = 2;
    localparam int CTRL_ALUOP_LSB = 0;

    // An all-zero word disables every write, memory access, branch and jump.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_stage_hazard_unit.sv
// Load-use hazard detection: stalls PC and IF/ID when the instruction in ID
// needs the register a load in EX is about to write.
module load_use_hazard_unit
    import id_ex_hazard_stage_pkg::*;
(
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_Rt,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  flush,
    output logic                  Stall,
    output logic                  PCWrite,
    output logic                  IF_IDWrite
);

    logic hazard;

    // A load into $0 never produces a value, and a flush kills the dependent
    // instruction anyway, so neither needs a stall.
    always_comb begin
        hazard     = EX_MemRead && (EX_Rt != '0) && ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));
        Stall      = hazard && !flush;
        PCWrite    = !Stall;
        IF_IDWrite = !Stall;
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX-requested flush
// and a saturating stall-cycle counter for performance debug.
module id_ex_hazard_stage
    import id_ex_hazard_stage_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [CTRL_W-1:0]      ID_Control,
    input  logic [WORD_LENGTH-1:0] ID_PC4,
    input  logic [WORD_LENGTH-1:0] ID_ReadData1,
    input  logic [WORD_LENGTH-1:0] ID_ReadData2,
    input  logic [WORD_LENGTH-1:0] ID_Imm,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic [4:0]             ID_Rd,
    input  logic [4:0]             ID_Shamt,
    input  logic [5:0]             ID_Funct,
    output logic [CTRL_W-1:0]      EX_Control,
    output logic [WORD_LENGTH-1:0] EX_PC4,
    output logic [WORD_LENGTH-1:0] EX_ReadData1,
    output logic [WORD_LENGTH-1:0] EX_ReadData2,
    output logic [WORD_LENGTH-1:0] EX_Imm,
    output logic [4:0]             EX_Rs,
    output logic [4:0]             EX_Rt,
    output logic [4:0]             EX_Rd,
    output logic [4:0]             EX_Shamt,
    output logic [5:0]             EX_Funct,
    output logic                   Stall,
    output logic                   PCWrite,
    output logic                   IF_IDWrite,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    logic [CTRL_W-1:0] controlNext;

    load_use_hazard_unit hazardUnit (
        .EX_MemRead (EX_Control[CTRL_MEMREAD]),
        .EX_Rt      (EX_Rt),
        .ID_Rs      (ID_Rs),
        .ID_Rt      (ID_Rt),
        .flush      (flush),
        .Stall      (Stall),
        .PCWrite    (PCWrite),
        .IF_IDWrite (IF_IDWrite)
    );

    // Flush and stall both turn the entering instruction into a bubble.
    always_comb begin
        controlNext = ID_Control;
        if (flush || Stall) begin
            controlNext = CTRL_BUBBLE;
        end
    end

    // Pipeline register; data fields load every cycle since a bubble ignores them.
    always_ff @(posedge clk) begin
        if (reset) begin
            EX_Control   <= CTRL_BUBBLE;
            EX_PC4       <= '0;
            EX_ReadData1 <= '0;
            EX_ReadData2 <= '0;
            EX_Imm       <= '0;
            EX_Rs        <= '0;
            EX_Rt        <= '0;
            EX_Rd        <= '0;
            EX_Shamt     <= '0;
            EX_Funct     <= '0;
        end else begin
            EX_Control   <= controlNext;
            EX_PC4       <= ID_PC4;
            EX_ReadData1 <= ID_ReadData1;
            EX_ReadData2 <= ID_ReadData2;
            EX_Imm       <= ID_Imm;
            EX_Rs        <= ID_Rs;
            EX_Rt        <= ID_Rt;
            EX_Rd        <= ID_Rd;
            EX_Shamt     <= ID_Shamt;
            EX_Funct     <= ID_Funct;
        end
    end

    // Stall-cycle counter that sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
        end else if (Stall && (StallCount != STALL_CNT_MAX)) begin
            StallCount <= StallCount + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: directed vectors, a behavioural
// reference model compared every cycle, and hand-computed literal checks.
module tb_id_ex_hazard_stage;

    localparam logic [12:0] CTRL_RTYPE = 13'h487;
    localparam logic [12:0] CTRL_LW    = 13'h3C3;
    localparam logic [12:0] CTRL_BEQ_W = 13'h008;
    localparam logic [12:0] CTRL_JAL_W = 13'h1880;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [12:0] idControl = '0;
    logic [31:0] idPc4 = '0, idReadData1 = '0, idReadData2 = '0, idImm = '0;
    logic [4:0]  idRs = '0, idRt = '0, idRd = '0, idShamt = '0;
    logic [5:0]  idFunct = '0;

    logic [12:0] exControl;
    logic [31:0] exPc4, exReadData1, exReadData2, exImm;
    logic [4:0]  exRs, exRt, exRd, exShamt;
    logic [5:0]  exFunct;
    logic        stall, pcWrite, ifIdWrite;
    logic [15:0] stallCount;

    logic [12:0] smallControl;
    logic [31:0] smallPc4, smallReadData1, smallReadData2, smallImm;
    logic [4:0]  smallRs, smallRt, smallRd, smallShamt;
    logic [5:0]  smallFunct;
    logic        smallStall, smallPcWrite, smallIfIdWrite;
    logic [3:0]  smallStallCount;

    int checks = 0;
    int errors = 0;
    int vecNum = 0;

    // Reference model state: what EX must hold and how many stalls were seen.
    logic [12:0] mCtrl;
    logic [31:0] mPc4, mRd1, mRd2, mImm;
    logic [4:0]  mRs, mRt, mRd, mShamt;
    logic [5:0]  mFunct;
    int          mStalls;
    bit          modelValid = 1'b0;

    always #5 clk = ~clk;

    id_ex_hazard_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ID_Control(idControl), .ID_PC4(idPc4), .ID_ReadData1(idReadData1),
        .ID_ReadData2(idReadData2), .ID_Imm(idImm), .ID_Rs(idRs), .ID_Rt(idRt),
        .ID_Rd(idRd), .ID_Shamt(idShamt), .ID_Funct(idFunct),
        .EX_Control(exControl), .EX_PC4(exPc4), .EX_ReadData1(exReadData1),
        .EX_ReadData2(exReadData2), .EX_Imm(exImm), .EX_Rs(exRs), .EX_Rt(exRt),
        .EX_Rd(exRd), .EX_Shamt(exShamt), .EX_Funct(exFunct),
        .Stall(stall), .PCWrite(pcWrite), .IF_IDWrite(ifIdWrite), .StallCount(stallCount)
    );

    id_ex_hazard_stage #(.WORD_LENGTH(32), .STALL_CNT_W(4)) dutSmall (
        .clk(clk), .reset(reset), .flush(flush),
        .ID_Control(idControl), .ID_PC4(idPc4), .ID_ReadData1(idReadData1),
        .ID_ReadData2(idReadData2), .ID_Imm(idImm), .ID_Rs(idRs), .ID_Rt(idRt),
        .ID_Rd(idRd), .ID_Shamt(idShamt), .ID_Funct(idFunct),
        .EX_Control(smallControl), .EX_PC4(smallPc4), .EX_ReadData1(smallReadData1),
        .EX_ReadData2(smallReadData2), .EX_Imm(smallImm), .EX_Rs(smallRs), .EX_Rt(smallRt),
        .EX_Rd(smallRd), .EX_Shamt(smallShamt), .EX_Funct(smallFunct),
        .Stall(smallStall), .PCWrite(smallPcWrite), .IF_IDWrite(smallIfIdWrite),
        .StallCount(smallStallCount)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Drive one ID instruction; data fields are derived from PC+4 so they differ per vector.
    task automatic applyStimulus(input logic [12:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [31:0] pc4, input logic fl);
        vecNum++;
        idControl   = ctrl;
        idRs        = rs;
        idRt        = rt;
        idPc4       = (pc4 != 32'h0) ? pc4 : 32'h0040_0000 + 32'(vecNum * 4);
        idReadData1 = idPc4 ^ 32'h1234_5678;
        idReadData2 = ~idPc4;
        idImm       = idPc4 + 32'h0000_0100;
        idRd        = rs ^ rt;
        idShamt     = rt + 5'd1;
        idFunct     = {1'b0, rs};
        flush       = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit modelStall();
        bit hazard;
        hazard = mCtrl[6] && (mRt != 5'd0) && ((mRt == idRs) || (mRt == idRt));
        return hazard && !flush;
    endfunction

    // Reference model advance, evaluated from inputs that were stable before the edge.
    always @(posedge clk) begin
        if (reset) begin
            mCtrl = '0; mPc4 = '0; mRd1 = '0; mRd2 = '0; mImm = '0;
            mRs = '0; mRt = '0; mRd = '0; mShamt = '0; mFunct = '0;
            mStalls = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (modelStall()) mStalls++;
            mCtrl  = (flush || modelStall()) ? 13'h0 : idControl;
            mPc4 = idPc4; mRd1 = idReadData1; mRd2 = idReadData2; mImm = idImm;
            mRs = idRs; mRt = idRt; mRd = idRd; mShamt = idShamt; mFunct = idFunct;
        end
    end

    // Every-cycle comparison of both DUT instances against the model.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("EX_Control", 32'(exControl), 32'(mCtrl));
            checkOutput("EX_PC4", exPc4, mPc4);
            checkOutput("EX_ReadData1", exReadData1, mRd1);
            checkOutput("EX_ReadData2", exReadData2, mRd2);
            checkOutput("EX_Imm", exImm, mImm);
            checkOutput("EX_Fields", {11'h0, exRs, exRt, exRd, exShamt, exFunct},
                        {11'h0, mRs, mRt, mRd, mShamt, mFunct});
            checkOutput("Stall", 32'(stall), 32'(modelStall()));
            checkOutput("PCWrite", 32'(pcWrite), 32'(!modelStall()));
            checkOutput("IF_IDWrite", 32'(ifIdWrite), 32'(!modelStall()));
            checkOutput("StallCount", 32'(stallCount), 32'((mStalls > 65535) ? 65535 : mStalls));
            checkOutput("smallControl", 32'(smallControl), 32'(mCtrl));
            checkOutput("smallStall", 32'(smallStall), 32'(modelStall()));
            checkOutput("smallStallCount", 32'(smallStallCount), 32'((mStalls > 15) ? 15 : mStalls));
        end
    end

    initial begin
        // Reset held two cycles with an R-type word waiting in ID.
        applyStimulus(CTRL_RTYPE, 5'd1, 5'd2, 32'h0, 1'b0);
        step();
        step();
        checkOutput("resetControl", 32'(exControl), 32'h0);
        checkOutput("resetCount", 32'(stallCount), 32'h0);
        checkOutput("resetPCWrite", 32'(pcWrite), 32'h1);
        reset = 1'b0;
        step();
        checkOutput("firstLoad", 32'(exControl), 32'h487);

        // Load-use pair: LW $t0 then a reader of $t0.
        applyStimulus(CTRL_LW, 5'd0, 5'd8, 32'h0, 1'b0);
        step();
        applyStimulus(CTRL_RTYPE, 5'd8, 5'd9, 32'h0, 1'b0);
        checkOutput("luStall", 32'(stall), 32'h1);
        checkOutput("luPCWrite", 32'(pcWrite), 32'h0);
        checkOutput("luIFIDWrite", 32'(ifIdWrite), 32'h0);
        step();
        checkOutput("luBubble", 32'(exControl), 32'h0);
        checkOutput("luCount", 32'(stallCount), 32'h1);
        checkOutput("luStallDrops", 32'(stall), 32'h0);
        step();

        // Load into $zero never stalls.
        applyStimulus(CTRL_LW, 5'd0, 5'd0, 32'h0, 1'b0);
        step();
        applyStimulus(CTRL_RTYPE, 5'd0, 5'd0, 32'h0, 1'b0);
        checkOutput("zeroStall", 32'(stall), 32'h0);
        step();
        checkOutput("zeroPass", 32'(exControl), 32'h487);

        // Load with no dependent reader.
        applyStimulus(CTRL_LW, 5'd1, 5'd9, 32'h0, 1'b0);
        step();
        applyStimulus(CTRL_RTYPE, 5'd10, 5'd11, 32'h0, 1'b0);
        checkOutput("indepStall", 32'(stall), 32'h0);
        step();
        checkOutput("indepPass", 32'(exControl), 32'h487);

        // Back-to-back independent loads.
        applyStimulus(CTRL_LW, 5'd1, 5'd9, 32'h0, 1'b0);
        step();
        applyStimulus(CTRL_LW, 5'd2, 5'd10, 32'h0, 1'b0);
        checkOutput("lwlwStall", 32'(stall), 32'h0);
        step();
        checkOutput("lwlwPass", 32'(exControl), 32'h3C3);

        // Flush overrides a live hazard.
        applyStimulus(CTRL_LW, 5'd0, 5'd8, 32'h0, 1'b0);
        step();
        applyStimulus(CTRL_RTYPE, 5'd8, 5'd3, 32'h0, 1'b1);
        checkOutput("flushStall", 32'(stall), 32'h0);
        checkOutput("flushPCWrite", 32'(pcWrite), 32'h1);
        step();
        checkOutput("flushBubble", 32'(exControl), 32'h0);
        checkOutput("flushCount", 32'(stallCount), 32'h1);

        // BEQ and JAL words pass through unchanged.
        applyStimulus(CTRL_BEQ_W, 5'd4, 5'd5, 32'h0040_0008, 1'b0);
        step();
        checkOutput("beqControl", 32'(exControl), 32'h008);
        checkOutput("beqPC4", exPc4, 32'h0040_0008);
        applyStimulus(CTRL_JAL_W, 5'd0, 5'd0, 32'h0040_0008, 1'b0);
        step();
        checkOutput("jalControl", 32'(exControl), 32'h1880);
        checkOutput("jalPC4", exPc4, 32'h0040_0008);

        // Reset arriving while a stall is active.
        applyStimulus(CTRL_LW, 5'd0, 5'd8, 32'h0, 1'b0);
        step();
        applyStimulus(CTRL_RTYPE, 5'd8, 5'd9, 32'h0, 1'b0);
        checkOutput("midStall", 32'(stall), 32'h1);
        reset = 1'b1;
        step();
        checkOutput("midRstControl", 32'(exControl), 32'h0);
        checkOutput("midRstStall", 32'(stall), 32'h0);
        checkOutput("midRstPCWrite", 32'(pcWrite), 32'h1);
        checkOutput("midRstCount", 32'(stallCount), 32'h0);

        // Repeated LW $t0: every other cycle stalls, 40 edges give 20 stalls.
        applyStimulus(CTRL_LW, 5'd0, 5'd8, 32'h0, 1'b0);
        reset = 1'b0;
        step();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(CTRL_LW, 5'd0, 5'd8, 32'h0, 1'b0);
            step();
        end
        checkOutput("satSmall", 32'(smallStallCount), 32'hF);
        checkOutput("satWide", 32'(stallCount), 32'd20);
        step();
        step();
        checkOutput("satSmallHold", 32'(smallStallCount), 32'hF);

        applyStimulus(CTRL_RTYPE, 5'd1, 5'd2, 32'h0, 1'b0);
        step();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
